// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder/subtractor whose carry chain is cut into SEG-bit segments,
//   one register stage per segment (STAGES = WIDTH/SEG). Stage k resolves
//   segment k using the carry registered by stage k-1. Operand bits that are
//   not yet consumed travel forward with the beat, and finished sum segments
//   ride along in the same word, so every segment leaves the last stage
//   aligned. The valid/ready handshake stalls the whole pipe as one unit.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (= pipeline advance)
//   a, b       operands
//   cin        carry-in (borrow chain input in subtract mode)
//   sub        0: a + b + cin, 1: a + ~b + cin
//   out_valid  result valid
//   out_ready  downstream accepts the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       raw carry out of the MSB (1 = no borrow when subtracting)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module pipelined_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int STAGES = WIDTH / SEG;

   if ((SEG < 1) || (WIDTH < SEG) || (WIDTH % SEG != 0)) begin : g_cfg_err
      $error("pipelined_adder: WIDTH (%0d) must be a nonzero multiple of SEG (%0d)",
             WIDTH, SEG);
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;

   // Whole pipe moves together: it may advance whenever the output slot is
   // empty or being drained this cycle.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign b_eff    = sub ? ~b : b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SEG;       // lowest bit handled here
      localparam int YW = WIDTH - LO;    // B bits still unconsumed on entry

      // x word: bits below LO are finished sum, bits from LO up are operand A.
      logic [WIDTH-1:0] x_in;
      logic [WIDTH-1:0] x_d;
      logic [WIDTH-1:0] x_q;
      logic [YW-1:0]    y_in;
      logic             c_in;
      logic             v_in;
      logic [SEG-1:0]   seg_s;
      logic             seg_c;
      logic             vld_q;
      logic             c_q;

      if (k == 0) begin : g_src
         assign x_in = a;
         assign y_in = b_eff;
         assign c_in = cin;
         assign v_in = in_valid;
      end else begin : g_src
         assign x_in = g_stage[k-1].x_q;
         assign y_in = g_stage[k-1].g_fwd.y_q;
         assign c_in = g_stage[k-1].c_q;
         assign v_in = g_stage[k-1].vld_q;
      end

      assign {seg_c, seg_s} = {1'b0, x_in[LO +: SEG]} + {1'b0, y_in[SEG-1:0]}
                            + {{SEG{1'b0}}, c_in};

      always_comb begin
         x_d            = x_in;
         x_d[LO +: SEG] = seg_s;
      end

      // Data registers load on every advance, bubbles included; only the
      // valid bit distinguishes a bubble.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            x_q   <= '0;
            c_q   <= 1'b0;
         end else if (adv) begin
            vld_q <= v_in;
            x_q   <= x_d;
            c_q   <= seg_c;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         // Skew register: the B segments later stages still need.
         logic [YW-SEG-1:0] y_q;
         always_ff @(posedge clk) begin
            if (rst)      y_q <= '0;
            else if (adv) y_q <= y_in[YW-1:SEG];
         end
      end else begin : g_out
         // Final segment holds both operand MSBs, so the flags are formed
         // here and registered alongside the sum.
         logic ovf_q;
         logic zero_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               ovf_q  <= (x_in[WIDTH-1] == y_in[SEG-1]) &&
                         (seg_s[SEG-1] != x_in[WIDTH-1]);
               zero_q <= (x_d == '0);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].vld_q;
   assign sum       = g_stage[STAGES-1].x_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_out.ovf_q;
   assign zero      = g_stage[STAGES-1].g_out.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (32/8, 16/16, 64/8) share the
// operand bus; sel picks which one is driven and observed. Expected results
// are queued at acceptance and popped at delivery.
module tb_pipelined_adder;
   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, iv, ordy, cin_s, sub_s;
   logic [63:0] a_s, b_s;
   int          sel, cyc, ntest, nfail;
   res_t        exp_q[$];
   int          cyc_q[$];
   beat_t       bq[$];

   logic        iv0, iv1, iv2, irdy0, irdy1, irdy2, ov0, ov1, ov2;
   logic [31:0] sum0;
   logic [15:0] sum1;
   logic [63:0] sum2;
   logic        cout0, cout1, cout2, ovf0, ovf1, ovf2, zero0, zero1, zero2;
   logic        obs_irdy, obs_ov;
   res_t        obs;

   assign iv0 = iv && (sel == 0);
   assign iv1 = iv && (sel == 1);
   assign iv2 = iv && (sel == 2);

   pipelined_adder #(.WIDTH(32), .SEG(8)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(irdy0),
      .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s), .sub(sub_s),
      .out_valid(ov0), .out_ready(ordy), .sum(sum0),
      .cout(cout0), .ovf(ovf0), .zero(zero0));

   pipelined_adder #(.WIDTH(16), .SEG(16)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(irdy1),
      .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin_s), .sub(sub_s),
      .out_valid(ov1), .out_ready(ordy), .sum(sum1),
      .cout(cout1), .ovf(ovf1), .zero(zero1));

   pipelined_adder #(.WIDTH(64), .SEG(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(irdy2),
      .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
      .out_valid(ov2), .out_ready(ordy), .sum(sum2),
      .cout(cout2), .ovf(ovf2), .zero(zero2));

   always_comb begin
      obs_irdy = irdy0;
      obs_ov   = ov0;
      obs      = {32'd0, sum0, cout0, ovf0, zero0};
      case (sel)
         1: begin
            obs_irdy = irdy1;
            obs_ov   = ov1;
            obs      = {48'd0, sum1, cout1, ovf1, zero1};
         end
         2: begin
            obs_irdy = irdy2;
            obs_ov   = ov2;
            obs      = {sum2, cout2, ovf2, zero2};
         end
         default: ;
      endcase
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int w_of(input int s);
      return (s == 1) ? 16 : (s == 2) ? 64 : 32;
   endfunction

   function automatic int st_of(input int s);
      return (s == 1) ? 1 : (s == 2) ? 8 : 4;
   endfunction

   function automatic logic [63:0] mask(input int w);
      return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
   endfunction

   // Golden model: one full-width add, flags from the operand/result MSBs.
   function automatic res_t model(input int w, input beat_t bt);
      logic [63:0] m, av, bv;
      logic [64:0] full;
      res_t        r;
      m      = mask(w);
      av     = bt.a & m;
      bv     = (bt.sub ? ~bt.b : bt.b) & m;
      full   = {1'b0, av} + {1'b0, bv} + {64'd0, bt.cin};
      r.sum  = full[63:0] & m;
      r.cout = full[w];
      r.ovf  = (av[w-1] == bv[w-1]) && (r.sum[w-1] != av[w-1]);
      r.zero = (r.sum == 64'd0);
      return r;
   endfunction

   function automatic beat_t rand_beat(input int w);
      beat_t bt;
      bt.a   = {$urandom(), $urandom()} & mask(w);
      bt.b   = {$urandom(), $urandom()} & mask(w);
      bt.cin = 1'($urandom());
      bt.sub = 1'($urandom());
      return bt;
   endfunction

   task automatic drive(input beat_t bt);
      a_s   = bt.a;
      b_s   = bt.b;
      cin_s = bt.cin;
      sub_s = bt.sub;
   endtask

   task automatic test_reset();
      rst = 1'b1; iv = 1'b0; ordy = 1'b0;
      drive('0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         ntest++;
         if (obs_ov !== 1'b0 || obs !== '0 || obs_irdy !== 1'b1) begin
            nfail++;
            $display("FAIL reset sel=%0d: out_valid=%b sum=%h cout=%b ovf=%b zero=%b in_ready=%b, required 0 0 0 0 0 1",
                     s, obs_ov, obs.sum, obs.cout, obs.ovf, obs.zero, obs_irdy);
         end
      end
   endtask

   // Carry across every segment, signed overflow, and subtract with borrow.
   task automatic test_directed(input int s);
      logic [63:0] m;
      res_t        hand[3];
      res_t        e;
      beat_t       bt;
      int          c, i, guard;
      sel = s;
      m   = mask(w_of(s));
      bq.delete();
      bt = '{m, 64'd1, 1'b0, 1'b0};               bq.push_back(bt);
      bt = '{m >> 1, 64'd1, 1'b0, 1'b0};          bq.push_back(bt);
      bt = '{64'd5, 64'd7, 1'b1, 1'b1};           bq.push_back(bt);
      hand[0] = '{64'd0, 1'b1, 1'b0, 1'b1};
      hand[1] = '{m ^ (m >> 1), 1'b0, 1'b1, 1'b0};
      hand[2] = '{m & ~64'd1, 1'b0, 1'b0, 1'b0};
      i = 0; guard = 0;
      while ((i < 3 || exp_q.size() > 0) && guard < 100) begin
         @(negedge clk);
         ordy = 1'b1;
         iv   = (i < 3);
         if (i < 3) drive(bq[i]);
         #1;
         if (obs_ov && ordy) begin
            if (exp_q.size() == 0) begin
               ntest++; nfail++;
               $display("FAIL directed_extra sel=%0d: got sum=%h, required no result", s, obs.sum);
            end else begin
               e = exp_q.pop_front(); c = cyc_q.pop_front();
               ntest += 2;
               if (obs !== e) begin
                  nfail++;
                  $display("FAIL directed sel=%0d: got sum=%h c/o/z=%b%b%b, required sum=%h c/o/z=%b%b%b",
                           s, obs.sum, obs.cout, obs.ovf, obs.zero, e.sum, e.cout, e.ovf, e.zero);
               end
               if (cyc - c != st_of(s)) begin
                  nfail++;
                  $display("FAIL directed_latency sel=%0d: got %0d, required %0d", s, cyc - c, st_of(s));
               end
            end
         end
         if (iv && obs_irdy) begin
            exp_q.push_back(hand[i]); cyc_q.push_back(cyc); i++;
         end
         guard++;
      end
      iv = 1'b0;
      if (guard >= 100) begin
         ntest++; nfail++;
         $display("FAIL directed_timeout sel=%0d: %0d results outstanding, required 0", s, exp_q.size());
         exp_q.delete(); cyc_q.delete();
      end
   endtask

   task automatic test_back_to_back(input int s);
      res_t e;
      int   c, i, guard;
      sel = s;
      bq.delete();
      for (int k = 0; k < 16; k++) bq.push_back(rand_beat(w_of(s)));
      i = 0; guard = 0;
      while ((i < 16 || exp_q.size() > 0) && guard < 200) begin
         @(negedge clk);
         ordy = 1'b1;
         iv   = (i < 16);
         if (i < 16) drive(bq[i]);
         #1;
         if (obs_ov && ordy) begin
            if (exp_q.size() == 0) begin
               ntest++; nfail++;
               $display("FAIL b2b_extra sel=%0d: got sum=%h, required no result", s, obs.sum);
            end else begin
               e = exp_q.pop_front(); c = cyc_q.pop_front();
               ntest += 2;
               if (obs !== e) begin
                  nfail++;
                  $display("FAIL b2b sel=%0d: got sum=%h c/o/z=%b%b%b, required sum=%h c/o/z=%b%b%b",
                           s, obs.sum, obs.cout, obs.ovf, obs.zero, e.sum, e.cout, e.ovf, e.zero);
               end
               if (cyc - c != st_of(s)) begin
                  nfail++;
                  $display("FAIL b2b_latency sel=%0d: got %0d, required %0d", s, cyc - c, st_of(s));
               end
            end
         end
         if (iv && obs_irdy) begin
            exp_q.push_back(model(w_of(s), bq[i])); cyc_q.push_back(cyc); i++;
         end
         guard++;
      end
      iv = 1'b0;
      if (guard >= 200) begin
         ntest++; nfail++;
         $display("FAIL b2b_timeout sel=%0d: %0d results outstanding, required 0", s, exp_q.size());
         exp_q.delete(); cyc_q.delete();
      end
   endtask

   task automatic test_backpressure();
      res_t e, held;
      int   i, guard, ndel;
      bit   seen;
      sel = 0;
      bq.delete();
      for (int k = 0; k < 6; k++) bq.push_back(rand_beat(32));
      i = 0; seen = 1'b0;
      // Phase 1: downstream blocked; four beats fill the pipe, then it holds.
      repeat (8) begin
         @(negedge clk);
         ordy = 1'b0;
         iv   = (i < 6);
         if (i < 6) drive(bq[i]);
         #1;
         if (obs_ov) begin
            if (!seen) begin
               held = obs; seen = 1'b1;
            end else begin
               ntest++;
               if (obs !== held) begin
                  nfail++;
                  $display("FAIL bp_hold: sum=%h changed while stalled, required %h", obs.sum, held.sum);
               end
            end
         end
         if (iv && obs_irdy) begin
            exp_q.push_back(model(32, bq[i])); cyc_q.push_back(cyc); i++;
         end
      end
      ntest++;
      if (i != 4) begin
         nfail++;
         $display("FAIL bp_accepted: got %0d beats accepted, required 4", i);
      end
      ntest++;
      if (obs_irdy !== 1'b0 || obs_ov !== 1'b1) begin
         nfail++;
         $display("FAIL bp_stalled: in_ready=%b out_valid=%b, required 0 1", obs_irdy, obs_ov);
      end
      // Phase 2: release; everything drains in order.
      ndel = 0; guard = 0;
      while ((i < 6 || exp_q.size() > 0) && guard < 100) begin
         @(negedge clk);
         ordy = 1'b1;
         iv   = (i < 6);
         if (i < 6) drive(bq[i]);
         #1;
         if (obs_ov && ordy) begin
            ndel++;
            if (exp_q.size() == 0) begin
               ntest++; nfail++;
               $display("FAIL bp_extra: got sum=%h, required no result", obs.sum);
            end else begin
               e = exp_q.pop_front(); void'(cyc_q.pop_front());
               ntest++;
               if (obs !== e) begin
                  nfail++;
                  $display("FAIL bp_order: got sum=%h c/o/z=%b%b%b, required sum=%h c/o/z=%b%b%b",
                           obs.sum, obs.cout, obs.ovf, obs.zero, e.sum, e.cout, e.ovf, e.zero);
               end
            end
         end
         if (iv && obs_irdy) begin
            exp_q.push_back(model(32, bq[i])); cyc_q.push_back(cyc); i++;
         end
         guard++;
      end
      iv = 1'b0;
      ntest++;
      if (ndel != 6 || guard >= 100) begin
         nfail++;
         $display("FAIL bp_count: got %0d results, required 6", ndel);
         exp_q.delete(); cyc_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      res_t  e;
      beat_t bt;
      int    c, i, guard;
      sel = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ordy = 1'b1;
         iv   = 1'b1;
         drive(rand_beat(32));
         #1;
         ntest++;
         if (obs_irdy !== 1'b1) begin
            nfail++;
            $display("FAIL rstmid_fill: in_ready=%b, required 1", obs_irdy);
         end
      end
      // Offer a beat while reset is high; it must be ignored.
      @(negedge clk);
      rst = 1'b1;
      drive(rand_beat(32));
      @(negedge clk);
      rst = 1'b0;
      iv  = 1'b0;
      #1;
      ntest++;
      if (obs_ov !== 1'b0) begin
         nfail++;
         $display("FAIL rstmid_valid: out_valid=%b after reset, required 0", obs_ov);
      end
      repeat (8) begin
         @(negedge clk);
         #1;
         ntest++;
         if (obs_ov !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_stale: out_valid=%b sum=%h, required no result", obs_ov, obs.sum);
         end
      end
      bt = rand_beat(32);
      i = 0; guard = 0;
      while ((i < 1 || exp_q.size() > 0) && guard < 50) begin
         @(negedge clk);
         ordy = 1'b1;
         iv   = (i < 1);
         drive(bt);
         #1;
         if (obs_ov && ordy) begin
            if (exp_q.size() == 0) begin
               ntest++; nfail++;
               $display("FAIL rstmid_extra: got sum=%h, required no result", obs.sum);
            end else begin
               e = exp_q.pop_front(); c = cyc_q.pop_front();
               ntest += 2;
               if (obs !== e) begin
                  nfail++;
                  $display("FAIL rstmid_fresh: got sum=%h c/o/z=%b%b%b, required sum=%h c/o/z=%b%b%b",
                           obs.sum, obs.cout, obs.ovf, obs.zero, e.sum, e.cout, e.ovf, e.zero);
               end
               if (cyc - c != 4) begin
                  nfail++;
                  $display("FAIL rstmid_latency: got %0d, required 4", cyc - c);
               end
            end
         end
         if (iv && obs_irdy) begin
            exp_q.push_back(model(32, bt)); cyc_q.push_back(cyc); i++;
         end
         guard++;
      end
      iv = 1'b0;
      if (guard >= 50) begin
         ntest++; nfail++;
         $display("FAIL rstmid_timeout: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      ntest = 0; nfail = 0; sel = 0;
      rst = 1'b1; iv = 1'b0; ordy = 1'b0;
      test_reset();
      for (int s = 0; s < 3; s++) begin
         test_directed(s);
         test_back_to_back(s);
      end
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's 32-bit ripple-carry adder.
- Splits a WIDTH-bit carry chain into SEG-bit segments, one register stage per segment, so long adders close timing at high clock rates.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits between operand-producing logic and ALU/accumulator datapaths that need throughput of one operation per cycle.

Parameters:
WIDTH  32  operand/result width in bits; must be a multiple of SEG
SEG    8   segment width (bits resolved per pipeline stage); STAGES = WIDTH/SEG, STAGES >= 1

Ports:
clk        input   1      clock, all state on rising edge
rst        input   1      synchronous reset, active-high
in_valid   input   1      operand beat valid
in_ready   output  1      block can accept a beat this cycle
a          input   WIDTH  operand A
b          input   WIDTH  operand B
cin        input   1      carry-in (borrow chain input in subtract mode)
sub        input   1      0: A+B+cin; 1: A+~B+cin
out_valid  output  1      result valid
out_ready  input   1      downstream accepts result this cycle
sum        output  WIDTH  result, modulo 2^WIDTH
cout       output  1      raw carry out of MSB
ovf        output  1      signed two's-complement overflow
zero       output  1      sum == 0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all stage valid bits cleared. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 in the first cycle after reset.
- Accept: a beat is accepted when in_valid && in_ready. Delivery: a result is delivered when out_valid && out_ready.
- Stall: advance = !out_valid || out_ready, and in_ready = advance (combinational).
  - When advance=0, every stage register holds its value, including data, valid and internal carries.
  - Output signals stay stable while out_valid && !out_ready.
- Bubbles:
  - When advance=1, each stage loads from its predecessor.
  - Stage 0 loads the input beat, and its valid bit = in_valid.
  - Bubbles propagate and are not collapsed.
- Arithmetic:
  - Effective B: b_eff = sub ? ~b : b.
  - Stage k (0..STAGES-1) adds segment k of a and b_eff plus the carry registered from stage k-1. Stage 0 uses cin.
  - Upper, unprocessed segments are carried forward in skew registers.
  - Lower, finished sum segments are delayed so that all segments emerge aligned.
- Latency: exactly STAGES cycles from acceptance to out_valid when not stalled. Throughput: 1 result/cycle.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - zero = (sum == 0).
  - All three are registered with the final stage and aligned with sum.
- Subtract: sub=1, cin=1 gives A-B; sub=1, cin=0 gives A-B-1 (borrow-in). In subtract mode, cout=1 means no borrow.
- Ordering: results leave in acceptance order. No reordering, no drops, no duplicates.
- STAGES=1: a single registered ripple stage with latency 1; handshake rules unchanged.
- Reset mid-operation: all in-flight beats are discarded. out_valid=0 on the cycle after rst is sampled high. Input is ignored while rst=1.
- Simultaneous accept and deliver when the pipeline is full and out_ready=1: both occur in the same cycle with no bubble inserted.
- Configuration: WIDTH % SEG != 0 is a configuration error and must fail elaboration.

Test Plan:
- WIDTH=32, SEG=8: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles sum=0x00000000, cout=1, zero=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x80000000, ovf=1, cout=0. Then a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back stream of 16 random beats with out_ready=1 -> 16 results on consecutive cycles starting at cycle 4, in order, each matching a golden model (including cin, sub, flags).
- Backpressure: issue 6 beats while out_ready=0 -> in_ready drops after the pipeline fills (4 held), and sum holds stable. Raise out_ready -> all 6 delivered in order with none lost.
- Reset mid-stream: 3 beats in flight, then assert rst for 1 cycle -> out_valid=0 next cycle, no stale result ever appears, and a fresh beat afterwards has latency 4.
- Re-run the first and third scenarios with WIDTH=16, SEG=16 (STAGES=1) and WIDTH=64, SEG=8 (STAGES=8) -> latency 1 and 8 respectively, results match the model.
